// File: rtl/mfp_ahb_lite_master_arbiter_pkg.sv
// rtl/mfp_ahb_lite_master_arbiter_pkg.sv - AHB-Lite transfer encodings and master indices for the two-master arbiter
package mfp_ahb_lite_master_arbiter_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic MFP_AHB_M_CPU = 1'b0;
    localparam logic MFP_AHB_M_DMA = 1'b1;

    // NONSEQ and SEQ both carry a real transfer; bit 1 alone tells them apart from IDLE/BUSY
    function automatic logic htrans_req(input logic [1:0] htrans);
        return htrans[1];
    endfunction

endpackage

// File: rtl/mfp_ahb_lite_master_arbiter_grant.sv
// rtl/mfp_ahb_lite_master_arbiter_grant.sv - release detect, arbitration policy and grant register (MFP_AHB_ARB_ROUND_ROBIN_EN selects round robin)
module mfp_ahb_arb_grant
    import mfp_ahb_lite_master_arbiter_pkg::*;
#(
    parameter logic RESET_OWNER = 1'b0
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       hready_s_i,
    input  logic [1:0] htrans_m0_i,
    input  logic [1:0] htrans_m1_i,
    input  logic       hmastlock_m0_i,
    input  logic       hmastlock_m1_i,
    output logic       grant_o
);

    logic       grant_q;
    logic       grant_d;
    logic       req_0;
    logic       req_1;
    logic [1:0] htrans_g;
    logic       lock_g;
    logic       release_w;

    assign req_0 = htrans_req(htrans_m0_i);
    assign req_1 = htrans_req(htrans_m1_i);

    assign htrans_g = (grant_q == MFP_AHB_M_DMA) ? htrans_m1_i : htrans_m0_i;
    assign lock_g   = (grant_q == MFP_AHB_M_DMA) ? hmastlock_m1_i : hmastlock_m0_i;

    // BUSY/SEQ are not IDLE, so an owner mid-burst can never be pre-empted here
    assign release_w = hready_s_i & ~lock_g & (htrans_g == HTRANS_IDLE);

    always_comb begin
        grant_d = grant_q;
        if (release_w) begin
`ifdef MFP_AHB_ARB_ROUND_ROBIN_EN
            if (req_0 && req_1) begin
                grant_d = ~grant_q;
            end else if (req_0) begin
                grant_d = MFP_AHB_M_CPU;
            end else if (req_1) begin
                grant_d = MFP_AHB_M_DMA;
            end
`else
            if (req_0) begin
                grant_d = MFP_AHB_M_CPU;
            end else if (req_1) begin
                grant_d = MFP_AHB_M_DMA;
            end
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            grant_q <= RESET_OWNER;
        end else begin
            grant_q <= grant_d;
        end
    end

    assign grant_o = grant_q;

endmodule

// File: rtl/mfp_ahb_lite_master_arbiter.sv
// rtl/mfp_ahb_lite_master_arbiter.sv - two-master AHB-Lite arbiter top: data-phase owner and bus muxes (MFP_AHB_ARB_ROUND_ROBIN_EN selects round robin)
module mfp_ahb_lite_master_arbiter
    import mfp_ahb_lite_master_arbiter_pkg::*;
#(
    parameter int   AW          = 32,
    parameter int   DW          = 32,
    parameter logic RESET_OWNER = 1'b0
) (
    input  logic          HCLK,
    input  logic          HRESET,

    input  logic [AW-1:0] HADDR_M0,
    input  logic [2:0]    HBURST_M0,
    input  logic          HMASTLOCK_M0,
    input  logic [3:0]    HPROT_M0,
    input  logic [2:0]    HSIZE_M0,
    input  logic [1:0]    HTRANS_M0,
    input  logic          HWRITE_M0,
    input  logic [DW-1:0] HWDATA_M0,
    output logic [DW-1:0] HRDATA_M0,
    output logic          HREADY_M0,
    output logic          HRESP_M0,

    input  logic [AW-1:0] HADDR_M1,
    input  logic [2:0]    HBURST_M1,
    input  logic          HMASTLOCK_M1,
    input  logic [3:0]    HPROT_M1,
    input  logic [2:0]    HSIZE_M1,
    input  logic [1:0]    HTRANS_M1,
    input  logic          HWRITE_M1,
    input  logic [DW-1:0] HWDATA_M1,
    output logic [DW-1:0] HRDATA_M1,
    output logic          HREADY_M1,
    output logic          HRESP_M1,

    output logic [AW-1:0] HADDR_S,
    output logic [2:0]    HBURST_S,
    output logic          HMASTLOCK_S,
    output logic [3:0]    HPROT_S,
    output logic [2:0]    HSIZE_S,
    output logic [1:0]    HTRANS_S,
    output logic          HWRITE_S,
    output logic [DW-1:0] HWDATA_S,
    input  logic [DW-1:0] HRDATA_S,
    input  logic          HREADY_S,
    input  logic          HRESP_S,

    output logic          HMASTER
);

    logic grant;
    logic sel_dma;
    logic data_owner_q;
    logic data_owner_d;

    mfp_ahb_arb_grant #(
        .RESET_OWNER (RESET_OWNER)
    ) u_grant (
        .clk_i          (HCLK),
        .reset_i        (HRESET),
        .hready_s_i     (HREADY_S),
        .htrans_m0_i    (HTRANS_M0),
        .htrans_m1_i    (HTRANS_M1),
        .hmastlock_m0_i (HMASTLOCK_M0),
        .hmastlock_m1_i (HMASTLOCK_M1),
        .grant_o        (grant)
    );

    // The data phase follows the address phase that completed on this edge
    assign data_owner_d = HREADY_S ? grant : data_owner_q;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            data_owner_q <= RESET_OWNER;
        end else begin
            data_owner_q <= data_owner_d;
        end
    end

    assign sel_dma = (grant == MFP_AHB_M_DMA);

    assign HADDR_S     = sel_dma ? HADDR_M1     : HADDR_M0;
    assign HBURST_S    = sel_dma ? HBURST_M1    : HBURST_M0;
    assign HMASTLOCK_S = sel_dma ? HMASTLOCK_M1 : HMASTLOCK_M0;
    assign HPROT_S     = sel_dma ? HPROT_M1     : HPROT_M0;
    assign HSIZE_S     = sel_dma ? HSIZE_M1     : HSIZE_M0;
    assign HTRANS_S    = sel_dma ? HTRANS_M1    : HTRANS_M0;
    assign HWRITE_S    = sel_dma ? HWRITE_M1    : HWRITE_M0;

    assign HWDATA_S = (data_owner_q == MFP_AHB_M_DMA) ? HWDATA_M1 : HWDATA_M0;

    assign HRDATA_M0 = HRDATA_S;
    assign HRDATA_M1 = HRDATA_S;

    // The ungranted master sees a permanent wait state and holds its address phase
    assign HREADY_M0 = ~sel_dma & HREADY_S;
    assign HREADY_M1 =  sel_dma & HREADY_S;
    assign HRESP_M0  = ~sel_dma & HRESP_S;
    assign HRESP_M1  =  sel_dma & HRESP_S;

    assign HMASTER = grant;

endmodule
